// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch vs. data load/store) sharing one memory port.
// Data wins by default; a streak counter lets a waiting fetch through after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
    input  logic [31:0] mem_din,
    input  logic        mem_ack,
    output logic        timeout_err
);

    localparam int             CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LIM    = CW'(TIMEOUT);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [2:0]     STARVE_LIM = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state_q;
    logic [2:0]    streak_q;
    logic [CW-1:0] tmo_cnt_q;
    logic [CW-1:0] tmo_cnt_d;
    logic          tmo_hit_s;
    logic          gnt_if_s;
    logic          gnt_dat_s;

    logic          mem_cs_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_dout_q;
    logic          if_ack_q;
    logic          d_ack_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          timeout_err_q;

    // Arbitration decision, only meaningful while idle
    always_comb begin
        gnt_if_s  = 1'b0;
        gnt_dat_s = 1'b0;
        if (state_q == IDLE) begin
            if (if_req && (!d_req || (streak_q == STARVE_LIM))) begin
                gnt_if_s = 1'b1;
            end else if (d_req) begin
                gnt_dat_s = 1'b1;
            end else begin
                gnt_if_s  = 1'b0;
                gnt_dat_s = 1'b0;
            end
        end else begin
            gnt_if_s  = 1'b0;
            gnt_dat_s = 1'b0;
        end
    end

    // Next value of the busy-cycle counter and the timeout condition it implies
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + CNT_ONE;
        tmo_hit_s = (tmo_cnt_d == TMO_LIM);
    end

    // Main FSM; every output is a register so mem_cs drops directly on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            streak_q      <= 3'd0;
            tmo_cnt_q     <= {CW{1'b0}};
            mem_cs_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
            mem_dout_q    <= 32'h0000_0000;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            if_rdata_q    <= 32'h0000_0000;
            d_rdata_q     <= 32'h0000_0000;
            timeout_err_q <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_if_s) begin
                        state_q    <= BUSY_I;
                        mem_cs_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                        tmo_cnt_q  <= {CW{1'b0}};
                        streak_q   <= 3'd0;
                    end else if (gnt_dat_s) begin
                        state_q    <= BUSY_D;
                        mem_cs_q   <= 1'b1;
                        mem_we_q   <= d_we;
                        mem_addr_q <= d_addr;
                        mem_dout_q <= d_wdata;
                        tmo_cnt_q  <= {CW{1'b0}};
                        // Only data grants that actually bypass a waiting fetch count
                        if (if_req && (streak_q != 3'd7)) begin
                            streak_q <= streak_q + 3'd1;
                        end else begin
                            streak_q <= streak_q;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack || tmo_hit_s) begin
                        state_q  <= RESP;
                        mem_cs_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (state_q == BUSY_I) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_ack ? mem_din : 32'h0000_0000;
                        end else begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= mem_ack ? mem_din : 32'h0000_0000;
                        end
                        if (!mem_ack) begin
                            timeout_err_q <= 1'b1;
                        end else begin
                            timeout_err_q <= timeout_err_q;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    mem_cs_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_cs      = mem_cs_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_dout    = mem_dout_q;
    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, load/store timing, priority, starvation guard,
// timeout and ack/timeout race, latch isolation, and reset in the middle of an access.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_ack;
    logic        timeout_err;

    int checks;
    int failures;

    mem_arbiter #(.TIMEOUT(15), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .mem_ack    (mem_ack),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        mem_din  = 32'h0;
        mem_ack  = 1'b0;
        repeat (2) step();

        chk1("rst_cs",     mem_cs,      1'b0);
        chk1("rst_we",     mem_we,      1'b0);
        chk ("rst_addr",   mem_addr,    32'h0);
        chk ("rst_dout",   mem_dout,    32'h0);
        chk1("rst_if_ack", if_ack,      1'b0);
        chk1("rst_d_ack",  d_ack,       1'b0);
        chk ("rst_if_rd",  if_rdata,    32'h0);
        chk ("rst_d_rd",   d_rdata,     32'h0);
        chk1("rst_err",    timeout_err, 1'b0);

        // single load, minimum latency
        rst    = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0100;
        step();
        chk1("ld_cs",   mem_cs,   1'b1);
        chk1("ld_we",   mem_we,   1'b0);
        chk ("ld_addr", mem_addr, 32'h0000_0100);
        chk1("ld_noack", d_ack,   1'b0);
        mem_ack = 1'b1;
        mem_din = 32'h1234_5678;
        step();
        chk1("ld_ack",   d_ack,   1'b1);
        chk ("ld_rdata", d_rdata, 32'h1234_5678);
        chk1("ld_cs_off", mem_cs, 1'b0);
        chk1("ld_if_ack", if_ack, 1'b0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        step();
        chk1("ld_ack_pulse", d_ack,  1'b0);
        chk ("ld_hold",      d_rdata, 32'h1234_5678);

        // mem_ack while idle is ignored
        mem_ack = 1'b1;
        mem_din = 32'hDEAD_BEEF;
        step();
        chk1("idle_ack_cs",   mem_cs,  1'b0);
        chk1("idle_ack_dack", d_ack,   1'b0);
        chk ("idle_ack_hold", d_rdata, 32'h1234_5678);
        mem_ack = 1'b0;

        // simultaneous requests: store first, then fetch
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wdata = 32'hA5A5_A5A5;
        step();
        chk1("sim_we",   mem_we,   1'b1);
        chk ("sim_addr", mem_addr, 32'h0000_0040);
        chk ("sim_dout", mem_dout, 32'hA5A5_A5A5);
        mem_ack = 1'b1;
        mem_din = 32'h0BAD_F00D;
        step();
        chk1("sim_dack",  d_ack,  1'b1);
        chk1("sim_ifack", if_ack, 1'b0);
        chk ("st_rdata",  d_rdata, 32'h0BAD_F00D);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        step();
        chk1("sim_idle_cs", mem_cs, 1'b0);
        step();
        chk1("fe_cs",   mem_cs,   1'b1);
        chk1("fe_we",   mem_we,   1'b0);
        chk ("fe_addr", mem_addr, 32'h0000_0200);
        // address change during the fetch must not reach the port
        if_addr = 32'h0000_0300;
        step();
        chk ("latch_addr", mem_addr, 32'h0000_0200);
        mem_ack = 1'b1;
        mem_din = 32'hCAFE_0001;
        step();
        chk1("fe_ack",    if_ack,  1'b1);
        chk1("fe_dack",   d_ack,   1'b0);
        chk ("fe_rdata",  if_rdata, 32'hCAFE_0001);
        chk ("fe_d_hold", d_rdata,  32'h0BAD_F00D);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        step();
        chk1("fe_ack_pulse", if_ack,  1'b0);
        chk ("fe_hold",      if_rdata, 32'hCAFE_0001);

        // starvation guard: four data grants, then the fetch
        if_req = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0080;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("stv_data_addr", mem_addr, 32'h0000_0080);
            mem_ack = 1'b1;
            mem_din = 32'(k);
            step();
            chk1("stv_dack",  d_ack,  1'b1);
            chk ("stv_rdata", d_rdata, 32'(k));
            mem_ack = 1'b0;
            step();
        end
        step();
        chk ("stv_fetch_addr", mem_addr, 32'h0000_0300);
        chk1("stv_fetch_we",   mem_we,   1'b0);
        mem_ack = 1'b1;
        mem_din = 32'h0000_0055;
        step();
        chk1("stv_ifack",  if_ack,  1'b1);
        chk ("stv_ifdata", if_rdata, 32'h0000_0055);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        step();
        // streak cleared: with both pending data wins again
        if_req = 1'b1;
        step();
        chk("stv_reset_addr", mem_addr, 32'h0000_0080);
        mem_ack = 1'b1;
        mem_din = 32'h0000_0066;
        step();
        chk1("stv_reset_dack", d_ack, 1'b1);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        step();

        // ack arriving on the last allowed busy cycle wins over timeout
        d_req  = 1'b1;
        d_addr = 32'h0000_0044;
        step();
        for (int c = 2; c <= 15; c++) begin
            step();
            chk1("race_cs", mem_cs, 1'b1);
        end
        mem_ack = 1'b1;
        mem_din = 32'h0000_0999;
        step();
        chk1("race_dack",  d_ack,       1'b1);
        chk ("race_rdata", d_rdata,     32'h0000_0999);
        chk1("race_err",   timeout_err, 1'b0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        step();

        // timeout: memory never answers
        d_req  = 1'b1;
        d_addr = 32'h0000_0048;
        step();
        for (int c = 2; c <= 15; c++) begin
            step();
            chk1("tmo_cs",  mem_cs,      1'b1);
            chk1("tmo_err_early", timeout_err, 1'b0);
        end
        step();
        chk1("tmo_dack",  d_ack,       1'b1);
        chk ("tmo_rdata", d_rdata,     32'h0);
        chk1("tmo_err",   timeout_err, 1'b1);
        chk1("tmo_cs_off", mem_cs,     1'b0);
        d_req = 1'b0;
        step();
        chk1("tmo_err_idle", timeout_err, 1'b1);
        d_req  = 1'b1;
        d_addr = 32'h0000_004C;
        step();
        mem_ack = 1'b1;
        mem_din = 32'h0000_0777;
        step();
        chk1("post_tmo_dack", d_ack,       1'b1);
        chk ("post_tmo_rd",   d_rdata,     32'h0000_0777);
        chk1("tmo_sticky",    timeout_err, 1'b1);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        step();

        // reset in the middle of a store
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0060;
        d_wdata = 32'h0000_1111;
        step();
        chk1("mid_cs_before", mem_cs, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("mid_cs_async", mem_cs,      1'b0);
        chk1("mid_we",       mem_we,      1'b0);
        chk ("mid_addr",     mem_addr,    32'h0);
        chk ("mid_dout",     mem_dout,    32'h0);
        chk1("mid_err",      timeout_err, 1'b0);
        chk ("mid_drd",      d_rdata,     32'h0);
        chk ("mid_ifrd",     if_rdata,    32'h0);
        step();
        chk1("mid_no_dack", d_ack,  1'b0);
        chk1("mid_no_iack", if_ack, 1'b0);
        rst = 1'b0;
        chk1("rel_no_grant", mem_cs, 1'b0);
        step();
        chk1("rel_grant_cs", mem_cs,   1'b1);
        chk ("rel_addr",     mem_addr, 32'h0000_0060);
        mem_ack = 1'b1;
        mem_din = 32'h0000_ABCD;
        step();
        chk1("rel_dack", d_ack, 1'b1);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        step();
        chk1("rel_dack_pulse", d_ack, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: TIMEOUT, default 15, max cycles waited for mem_ack; STARVE_LIMIT, default 4, max consecutive data grants while fetch pending.
REQ-002 clk  input  1  main clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  fetch request; held high until if_ack seen.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_ack  output  1  fetch done, one-cycle pulse.
REQ-007 if_rdata  output  32  fetch data, valid while if_ack=1.
REQ-008 d_req  input  1  data (LW/SW) request; held high until d_ack seen.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ack  output  1  data access done, one-cycle pulse.
REQ-013 d_rdata  output  32  load data, valid while d_ack=1.
REQ-014 mem_cs  output  1  shared memory port select.
REQ-015 mem_we  output  1  shared port write enable.
REQ-016 mem_addr  output  32  shared port address.
REQ-017 mem_dout  output  32  shared port write data.
REQ-018 mem_din  input  32  shared port read data, valid with mem_ack.
REQ-019 mem_ack  input  1  memory completion, may arrive any cycle mem_cs=1.
REQ-020 timeout_err  output  1  sticky flag: an access timed out.

Function
REQ-021 FSM states: IDLE, BUSY_I, BUSY_D, RESP; one access outstanding at most.
REQ-022 IDLE: no requests -> stay; else grant per REQ-023/024, latch address/we/wdata into registers, go BUSY_I or BUSY_D.
REQ-023 Priority: data over fetch when both pending (structural-hazard rule: memory stage beats fetch).
REQ-024 Starvation guard: streak counter (3 bits) +1 on each data grant made while if_req=1, cleared on any fetch grant; both pending and streak==STARVE_LIMIT -> fetch granted.
REQ-025 BUSY_x: mem_cs=1, mem_addr/mem_we/mem_dout driven from latched registers only (requester input changes ignored); mem_we=0 in BUSY_I.
REQ-026 BUSY_x with mem_ack=1: capture mem_din into rdata register, go RESP.
REQ-027 Timeout: cycle counter cleared on grant, +1 each BUSY cycle without mem_ack; reaching TIMEOUT -> go RESP, rdata=32'h0, timeout_err<=1.
REQ-028 RESP: exactly one of if_ack/d_ack high for one cycle (matching granted port), mem_cs=0, no arbitration; next state IDLE.
REQ-029 Requester drops req at the edge ending its ack cycle; a request still high in IDLE afterwards is a new access.
REQ-030 Minimum latency: req high in cycle 0, mem_ack in cycle 1 -> ack in cycle 2; back-to-back access re-grant earliest cycle 3 (IDLE).
REQ-031 mem_ack while not in BUSY_x: ignored.
REQ-032 Store ack: d_rdata=captured mem_din (don't-care to requester), d_ack timing identical to load.
REQ-033 mem_ack in same cycle counter reaches TIMEOUT: ack wins, no error.
REQ-034 timeout_err cleared only by rst.
REQ-035 if_rdata/d_rdata hold last captured value outside ack cycles.

Reset
REQ-036 rst=1 asynchronously forces: state IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_dout=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, streak=0, timeout counter=0, timeout_err=0.
REQ-037 rst asserted mid-access: access abandoned, no ack generated; mem_cs falls without waiting for clk.
REQ-038 After rst release, first grant no earlier than first rising edge with rst=0.

Verification
REQ-039 Single load: d_req=1,d_we=0,d_addr=0x100; mem_ack=1,mem_din=0x1234_5678 in first BUSY cycle -> mem_cs 1 cycle, d_ack pulses 2 cycles after req, d_rdata=0x1234_5678.
REQ-040 Simultaneous: if_req=1 and d_req=1 (d_we=1,d_addr=0x40,d_wdata=0xA5A5_A5A5) -> data granted first (mem_we=1,mem_addr=0x40); fetch granted next IDLE.
REQ-041 Starvation: if_req held, d_req re-asserted after every d_ack -> after 4 data grants fetch granted 5th, streak reset to 0.
REQ-042 Timeout: d_req=1, mem_ack stuck 0 -> after 15 BUSY cycles d_ack=1, d_rdata=0, timeout_err=1 and stays 1 across later accesses.
REQ-043 Latch isolation: if_addr changed 0x200->0x300 during BUSY_I -> mem_addr stays 0x200.
REQ-044 Mid-access reset: rst pulsed during BUSY_D -> mem_cs=0 same cycle, no d_ack, all outputs at reset values.
